// File: rtl/puf_majority_vote.sv
// Sequences NUM_SAMPLES evaluations of the arbiter PUF core and majority-votes each response bit.
// Produces the voted response, a per-bit stability mask and the stable-bit count.
//
// state     | meaning
// IDLE      | waiting for start; results hold
// TRIG      | one-cycle puf_trig, timeout loaded
// WAIT_SMP  | waiting for PUF sample state (with timeout)
// SETTLE    | letting puf_out settle before capture
// ACCUM     | add puf_out into per-bit counts
// WAIT_IDLE | waiting for PUF idle before re-trigger (with timeout)
// FINISH    | results valid, done pulse
module puf_majority_vote #(
  parameter int WIDTH       = 96,
  parameter int NUM_SAMPLES = 15,
  parameter int SETTLE      = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [WIDTH-1:0]           response,
  output logic [WIDTH-1:0]           stable_mask,
  output logic [$clog2(WIDTH+1)-1:0] num_stable,
  output logic                       puf_trig,
  input  logic [2:0]                 puf_state,
  input  logic [WIDTH-1:0]           puf_out
);

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam int NS_W  = $clog2(WIDTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [2:0] PS_IDLE   = 3'b001;
  localparam logic [2:0] PS_SAMPLE = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_SMP, S_SETTLE, S_ACCUM, S_WAIT_IDLE, S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [CNT_W-1:0] iter_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic             tmo_zero;
  logic             timeout_hit;
  logic [WIDTH-1:0] resp_nxt;
  logic [WIDTH-1:0] mask_nxt;
  logic [NS_W-1:0]  ns_nxt;

  assign tmo_zero    = (tmo_cnt == '0);
  assign timeout_hit = tmo_zero &&
                       (((state == S_WAIT_SMP)  && (puf_state != PS_SAMPLE)) ||
                        ((state == S_WAIT_IDLE) && (puf_state != PS_IDLE)));

  assign puf_trig = (state == S_TRIG);
  assign done     = (state == S_FINISH);
  // busy covers the accepting IDLE cycle so back-to-back runs only drop it in FINISH
  assign busy     = (state == S_IDLE) ? start : (state != S_FINISH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_TRIG;
      S_TRIG:      state_nxt = S_WAIT_SMP;
      S_WAIT_SMP: begin
        if (puf_state == PS_SAMPLE) state_nxt = (SETTLE == 0) ? S_ACCUM : S_SETTLE;
        else if (tmo_zero)          state_nxt = S_FINISH;
      end
      S_SETTLE:    if (settle_cnt == '0) state_nxt = S_ACCUM;
      S_ACCUM:     state_nxt = (iter_cnt == CNT_W'(NUM_SAMPLES - 1)) ? S_FINISH : S_WAIT_IDLE;
      S_WAIT_IDLE: begin
        if (puf_state == PS_IDLE) state_nxt = S_TRIG;
        else if (tmo_zero)        state_nxt = S_FINISH;
      end
      S_FINISH:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Results are computed from the post-update counts so they are valid alongside done.
  always_comb begin
    resp_nxt = '0;
    mask_nxt = '0;
    ns_nxt   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if ((state == S_IDLE) && start)
        cnt_nxt[i] = '0;
      else if ((state == S_ACCUM) && puf_out[i] && (cnt[i] != CNT_W'(NUM_SAMPLES)))
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      resp_nxt[i] = (cnt_nxt[i] > CNT_W'(NUM_SAMPLES / 2));
      mask_nxt[i] = (cnt_nxt[i] == '0) || (cnt_nxt[i] == CNT_W'(NUM_SAMPLES));
      ns_nxt      = ns_nxt + NS_W'(mask_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      iter_cnt    <= '0;
      tmo_cnt     <= '0;
      settle_cnt  <= '0;
      error       <= 1'b0;
      response    <= '0;
      stable_mask <= '0;
      num_stable  <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
      case (state)
        S_IDLE: begin
          if (start) begin
            iter_cnt <= '0;
            error    <= 1'b0;
          end
        end
        S_TRIG: tmo_cnt <= TMO_W'(TIMEOUT);
        S_WAIT_SMP: begin
          if (!tmo_zero) tmo_cnt <= tmo_cnt - TMO_W'(1);
          if (puf_state == PS_SAMPLE) settle_cnt <= SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
        end
        S_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
        S_ACCUM: begin
          iter_cnt <= iter_cnt + CNT_W'(1);
          tmo_cnt  <= TMO_W'(TIMEOUT);
        end
        S_WAIT_IDLE: if (!tmo_zero) tmo_cnt <= tmo_cnt - TMO_W'(1);
        default: ;
      endcase
      if (timeout_hit) error <= 1'b1;
      if (state_nxt == S_FINISH) begin
        response    <= resp_nxt;
        stable_mask <= mask_nxt;
        num_stable  <= ns_nxt;
      end
    end
  end

endmodule

// File: tb/tb_puf_majority_vote.sv
// Directed bench for puf_majority_vote with a behavioural PUF core model driven on the falling edge.
module tb_puf_majority_vote;

  localparam int WIDTH   = 96;
  localparam int NS      = 15;
  localparam int TIMEOUT = 1024;
  localparam logic [95:0] A5 = {12{8'hA5}};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error, puf_trig;
  logic [95:0] response, stable_mask;
  logic [6:0]  num_stable;
  logic [2:0]  puf_state;
  logic [95:0] puf_out;

  puf_majority_vote #(.WIDTH(WIDTH), .NUM_SAMPLES(NS), .SETTLE(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .response(response), .stable_mask(stable_mask), .num_stable(num_stable),
    .puf_trig(puf_trig), .puf_state(puf_state), .puf_out(puf_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // model configuration (written by the stimulus thread only)
  int pattern = 0, extra = 0, exp_period = 0;
  bit hang = 1'b0;
  int trig_base = 0, eval_base = 0;
  int start_cyc = 0;
  // model state and statistics (written by the model thread only)
  int phase = 0, ph_cnt = 0;
  bit prev_trig = 1'b0;
  int trig_cnt = 0, eval_idx = 0, viol = 0, period_bad = 0;
  int last_trig_cyc = 0, first_trig_cyc = 0;

  function automatic logic [95:0] pat_val(input int p, input int idx);
    logic [95:0] v;
    int k;
    k = idx % NS;
    v = '0;
    case (p)
      0: v = A5;
      1: begin v[0] = (k < 8); v[1] = (k < 7); end
      2: v = '1;
      3: begin v[47:0] = 48'hDEADBEEF1234; v[95:48] = (k < 5) ? '1 : '0; end
      default: v = '0;
    endcase
    return v;
  endfunction

  // PUF core: 010 for a cycle, 011 for 3, 100 for 2, optional extra 011, then 001
  initial begin
    puf_state = 3'b001;
    puf_out   = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        phase = 0; ph_cnt = 0; puf_state = 3'b001; prev_trig = 1'b0;
      end else begin
        if (puf_trig) begin
          if (phase != 0 || prev_trig) viol++;
          if (trig_cnt == trig_base) first_trig_cyc = cyc;
          else if (exp_period > 0 && (cyc - last_trig_cyc) != exp_period) period_bad++;
          last_trig_cyc = cyc;
          trig_cnt++;
          puf_out = pat_val(pattern, eval_idx - eval_base);
          eval_idx++;
        end
        prev_trig = puf_trig;
        case (phase)
          0: if (puf_trig) begin puf_state = 3'b010; phase = 1; end
          1: begin puf_state = 3'b011; ph_cnt = 2; phase = 2; end
          2: if (!hang) begin
               if (ph_cnt == 0) begin puf_state = 3'b100; ph_cnt = 1; phase = 3; end
               else ph_cnt--;
             end
          3: if (ph_cnt == 0) begin
               if (extra > 0) begin puf_state = 3'b011; ph_cnt = extra - 1; phase = 4; end
               else begin puf_state = 3'b001; phase = 0; end
             end else ph_cnt--;
          4: if (ph_cnt == 0) begin puf_state = 3'b001; phase = 0; end
             else ph_cnt--;
          default: phase = 0;
        endcase
      end
    end
  end

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int dcyc, output int ok);
    ok = 0;
    dcyc = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1;
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic check_zero_outputs(input string tg);
    chki({tg, "_busy"}, int'(busy), 0);
    chki({tg, "_done"}, int'(done), 0);
    chki({tg, "_error"}, int'(error), 0);
    chki({tg, "_trig"}, int'(puf_trig), 0);
    chkv({tg, "_resp"}, response, '0);
    chkv({tg, "_mask"}, stable_mask, '0);
    chki({tg, "_nstable"}, int'(num_stable), 0);
  endtask

  task automatic run_normal(input string tg, input int p, input int e, input int per,
                            input logic [95:0] hold, input logic [95:0] er,
                            input logic [95:0] em, input int en);
    int dcyc, ok, vb, pb;
    repeat (8) @(negedge clk);
    pattern = p; extra = e; exp_period = per; hang = 1'b0;
    trig_base = trig_cnt; eval_base = eval_idx;
    vb = viol; pb = period_bad;
    pulse_start();
    chki({tg, "_trig_now"}, int'(puf_trig), 1);
    chki({tg, "_err_clr"}, int'(error), 0);
    chkv({tg, "_hold"}, response, hold);
    wait_done(3000, dcyc, ok);
    chki({tg, "_done_seen"}, ok, 1);
    chki({tg, "_ntrig"}, trig_cnt - trig_base, NS);
    chki({tg, "_latency"}, first_trig_cyc - start_cyc, 1);
    chki({tg, "_viol"}, viol - vb, 0);
    chki({tg, "_period"}, period_bad - pb, 0);
    chkv({tg, "_resp"}, response, er);
    chkv({tg, "_mask"}, stable_mask, em);
    chki({tg, "_nstable"}, int'(num_stable), en);
    chki({tg, "_error"}, int'(error), 0);
    chki({tg, "_busy"}, int'(busy), 0);
    @(negedge clk);
    chki({tg, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    int dcyc, ok, reached, dn, runs, busy_bad, run_base, vb;

    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b1;

    run_normal("const", 0, 0, 9, '0, A5, '1, 96);
    run_normal("split", 1, 0, 9, A5, 96'h1, ~96'h3, 94);
    run_normal("tail", 2, 5, 12, 96'h1, '1, '1, 96);

    // PUF never reaches the sample state
    repeat (8) @(negedge clk);
    pattern = 0; extra = 0; exp_period = 0; hang = 1'b1;
    trig_base = trig_cnt; eval_base = eval_idx;
    pulse_start();
    chki("to_trig_now", int'(puf_trig), 1);
    wait_done(3000, dcyc, ok);
    chki("to_done_seen", ok, 1);
    chki("to_error", int'(error), 1);
    chki("to_delay", dcyc - last_trig_cyc, TIMEOUT + 2);
    chki("to_ntrig", trig_cnt - trig_base, 1);
    chkv("to_resp", response, '0);
    chkv("to_mask", stable_mask, '1);
    chki("to_nstable", int'(num_stable), 96);
    chki("to_busy", int'(busy), 0);
    @(negedge clk);
    chki("to_done_pulse", int'(done), 0);
    hang = 1'b0;
    repeat (10) @(negedge clk);
    chki("to_error_held", int'(error), 1);

    run_normal("after_to", 3, 0, 9, '0, {48'h0, 48'hDEADBEEF1234}, {48'h0, {48{1'b1}}}, 48);

    // reset during the 7th evaluation
    repeat (8) @(negedge clk);
    pattern = 0; extra = 0; exp_period = 9;
    trig_base = trig_cnt; eval_base = eval_idx;
    pulse_start();
    reached = 0;
    for (int i = 0; i < 500; i++) begin
      if (trig_cnt - trig_base >= 7) begin reached = 1; break; end
      @(negedge clk);
    end
    chki("rst_reach7", reached, 1);
    #2 reset = 1'b0;
    #1 check_zero_outputs("rst_mid");
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    chki("rst_no_done", dn, 0);
    reset = 1'b1;

    run_normal("post_rst", 1, 0, 9, '0, 96'h1, ~96'h3, 94);

    // start held high: three back-to-back runs
    repeat (8) @(negedge clk);
    pattern = 0; extra = 0; exp_period = 0;
    trig_base = trig_cnt; eval_base = eval_idx;
    run_base = trig_cnt; vb = viol;
    runs = 0; busy_bad = 0;
    start = 1'b1;
    for (int i = 0; i < 2000 && runs < 3; i++) begin
      @(negedge clk);
      if (busy !== !done) busy_bad++;
      if (done === 1'b1) begin
        runs++;
        chki("b2b_ntrig", trig_cnt - run_base, NS);
        chkv("b2b_resp", response, A5);
        run_base = trig_cnt;
        if (runs == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    chki("b2b_runs", runs, 3);
    chki("b2b_busy", busy_bad, 0);
    chki("b2b_viol", viol - vb, 0);
    repeat (3) @(negedge clk);
    chki("b2b_stopped", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
